// File: rtl/serial_row_loader_if.sv
// Bus bundle for serial_row_loader: serial input, load configuration and the
// row-memory write port with status flags.
interface serial_row_loader_if #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
);
    logic                  S;
    logic [3:0]            feat;
    logic [ADDR_WIDTH-1:0] data_points;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  load_done;

    modport master (
        output S, feat, data_points,
        input  wr_en, wr_addr, wr_data, busy, load_done
    );

    modport slave (
        input  S, feat, data_points,
        output wr_en, wr_addr, wr_data, busy, load_done
    );
endinterface

// File: rtl/serial_row_loader.sv
// Deserialises a gap-free LSB-first bit stream into rows of F+1 words (highest
// word index first) and writes each completed row to row memory.
module serial_row_loader #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    serial_row_loader_if.slave   bus
);
    localparam int BIT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    typedef enum logic {
        RECV = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            feat_q;
    logic [ADDR_WIDTH-1:0] npts_q;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]            word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] point_cnt_q, point_cnt_d;
    logic [DATA_WIDTH-1:0] row_q, row_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  last_bit, last_word;

    assign last_bit  = (bit_cnt_q == BIT_W'(LENGTH - 1));
    assign last_word = (word_cnt_q == 4'd0);

    // Each word lane captures the incoming bit only while it is the active word,
    // so lanes above F are never touched and stay zero.
    genvar gi;
    generate
        for (gi = 0; gi <= MAX_FEATURES; gi++) begin : g_lane
            logic [LENGTH-1:0] lane;
            always_comb begin
                lane = row_q[gi*LENGTH +: LENGTH];
                if (word_cnt_q == 4'(gi)) begin
                    lane[bit_cnt_q] = bus.S;
                end
            end
            assign row_d[gi*LENGTH +: LENGTH] = lane;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        point_cnt_d = point_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (state_q == RECV) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + BIT_W'(1);
            if (last_bit) begin
                word_cnt_d = last_word ? feat_q : word_cnt_q - 4'd1;
                if (last_word) begin
                    // The output row is taken from row_d so the final bit lands in it.
                    wr_en_d   = 1'b1;
                    wr_addr_d = point_cnt_q;
                    wr_data_d = row_d;
                    if (point_cnt_q == npts_q - ADDR_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        point_cnt_d = point_cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            feat_q      <= bus.feat;
            npts_q      <= bus.data_points;
            state_q     <= (bus.data_points == '0) ? DONE : RECV;
            bit_cnt_q   <= '0;
            word_cnt_q  <= bus.feat;
            point_cnt_q <= '0;
            row_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            point_cnt_q <= point_cnt_d;
            if (state_q == RECV) begin
                row_q <= row_d;
            end
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state_q == RECV) && !RST;
    assign bus.load_done = (state_q == DONE) && !RST;
endmodule

// File: doc/serial_row_loader.md
SERIAL_ROW_LOADER -- requirements
Module: serial_row_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, width of data-point count and write address.
REQ-002 SHALL have parameter MAX_FEATURES, default 15, maximum feature index supported.
REQ-003 SHALL have parameter LENGTH, default 16, bits per serial word.
REQ-004 SHALL have parameter DATA_WIDTH, default LENGTH*(MAX_FEATURES+1), width of one assembled row.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 S  input  1  serial data, one bit sampled per CLK cycle while receiving.
REQ-008 feat  input  4  feature count F; each data point carries F+1 words (F features plus y).
REQ-009 data_points  input  ADDR_WIDTH  number of rows N to load.
REQ-010 wr_en  output  1  one-cycle row write strobe to row memory.
REQ-011 wr_addr  output  ADDR_WIDTH  row index for current write.
REQ-012 wr_data  output  DATA_WIDTH  assembled row.
REQ-013 busy  output  1  high while in RECV.
REQ-014 load_done  output  1  high once all N rows written; held until reset.

Function
REQ-015 SHALL register feat and data_points on every cycle RST is high; the values held when RST falls are used for the whole load.
REQ-016 SHALL implement states RECV and DONE; reset enters RECV, or DONE if latched data_points = 0.
REQ-017 Cycle 0 = first rising edge with RST low; stream bit b SHALL be sampled at edge b, no gaps, no start bit, no valid qualifier.
REQ-018 Words SHALL be LSB-first: bit x of a word arrives at in-word position x (0..LENGTH-1).
REQ-019 Within a point, words SHALL arrive in order index F, F-1, ..., 0; word index j SHALL be placed at wr_data[LENGTH*j +: LENGTH].
REQ-020 wr_data words with index greater than F SHALL be zero.
REQ-021 On the edge sampling the last bit of word 0 of point k, SHALL register wr_data with the full row, wr_addr = k, wr_en = 1; wr_en SHALL drop the next cycle.
REQ-022 Reception of point k+1 SHALL continue on the immediately following edge; the next row SHALL not corrupt wr_data before its own write.
REQ-023 Point k write strobe SHALL be visible after edge LENGTH*(F+1)*(k+1)-1.
REQ-024 On the write of point N-1 SHALL enter DONE; load_done SHALL rise on the same edge as that wr_en.
REQ-025 In DONE, S SHALL be ignored, wr_en stays 0, wr_addr/wr_data hold last values.
REQ-026 Bit counter SHALL wrap LENGTH-1 -> 0; word counter SHALL count F down to 0 then reload F; point counter SHALL count 0 to N-1 with no wrap.
REQ-027 feat = 0 SHALL give one word per row; feat = 15 SHALL fill all DATA_WIDTH bits.
REQ-028 busy SHALL equal (state == RECV) and be 0 during RST.

Reset
REQ-029 RST high SHALL force wr_en = 0, wr_addr = 0, wr_data = 0, load_done = 0, busy = 0, and clear all counters and the partial row.
REQ-030 RST asserted mid-row or mid-load SHALL discard the partial row; after release loading restarts at row 0 with bit 0 at cycle 0.

Verification
REQ-031 feat=11, N=5, row k word j = 16'h0k0j (e.g. k=2,j=7 -> 16'h0207), streamed words 11..0 LSB-first -> five wr_en pulses at cycles 191, 383, 575, 767, 959, wr_addr 0..4, upper 4 words zero, load_done high from cycle 959.
REQ-032 feat=0, N=3, words 16'hA5A5, 16'h0001, 16'hFFFF -> wr_en at cycles 15, 31, 47, wr_data low word matches, all other bits 0.
REQ-033 feat=15, N=1, word j = 16'h1111*j (j=0..15 mod 16 bits) -> single wr_en at cycle 255 with all 16 words at correct offsets.
REQ-034 data_points=0 -> no wr_en ever, load_done=1 and busy=0 from first cycle after RST falls.
REQ-035 feat=2, N=2, RST pulsed high 1 cycle at cycle 30, restream from scratch -> no write from aborted data, writes at cycles 47 and 95 relative to new cycle 0, addresses 0 and 1.
REQ-036 After load_done, drive S random for 100 cycles -> wr_en stays 0, wr_data/wr_addr unchanged.
